// File: rtl/vga_pkg.sv
// vga_pkg: framebuffer geometry and arbiter state type shared by the VRAM arbiter
package vga_pkg;
  localparam int FB_W = 160;
  localparam int FB_H = 120;
  localparam int FB_DEPTH = 19200;
  localparam int FB_ADDR_W = 15;
  typedef enum logic {IDLE, CLEAR} arb_state_t;
endpackage

// File: rtl/fb_addr.sv
// fb_addr: framebuffer linear address y*160+x built from shifts and adds
module fb_addr
  import vga_pkg::*;
(
  input  logic [7:0]           i_x,
  input  logic [6:0]           i_y,
  output logic [FB_ADDR_W-1:0] o_addr
);
  logic [FB_ADDR_W-1:0] w_y;
  assign w_y = {8'd0, i_y};
  assign o_addr = (w_y << 7) + (w_y << 5) + {7'd0, i_x};
endmodule

// File: rtl/vram_arbiter.sv
// vram_arbiter: shares one frame memory port between display reads, draw writes and a fill engine
module vram_arbiter
  import vga_pkg::*;
#(
  parameter int PIX_W = 8,
  parameter int SCALE_SHIFT = 2
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 pix_en,
  input  logic [9:0]           xcoord,
  input  logic [9:0]           ycoord,
  input  logic                 nocolor,
  input  logic                 wr_valid,
  output logic                 wr_ready,
  input  logic [7:0]           wr_x,
  input  logic [6:0]           wr_y,
  input  logic [PIX_W-1:0]     wr_data,
  input  logic                 clear_req,
  input  logic [PIX_W-1:0]     clear_color,
  output logic                 clear_busy,
  output logic                 clear_done,
  output logic                 wr_drop,
  output logic [FB_ADDR_W-1:0] mem_addr,
  output logic                 mem_we,
  output logic [PIX_W-1:0]     mem_wdata,
  input  logic [PIX_W-1:0]     mem_rdata,
  output logic [PIX_W-1:0]     pixel,
  output logic                 pixel_valid
);
  arb_state_t           r_state;
  logic [FB_ADDR_W-1:0] r_fill, w_daddr, w_waddr;
  logic [PIX_W-1:0]     r_color, r_pixel;
  logic                 r_slot, r_done, r_drop;
  logic                 w_disp, w_clr, w_in, w_xfer, w_last;

  fb_addr u_disp_addr (
    .i_x   (8'(xcoord >> SCALE_SHIFT)),
    .i_y   (7'(ycoord >> SCALE_SHIFT)),
    .o_addr(w_daddr)
  );

  fb_addr u_wr_addr (
    .i_x   (wr_x),
    .i_y   (wr_y),
    .o_addr(w_waddr)
  );

  assign w_disp = pix_en && !nocolor;
  assign w_clr = r_state == CLEAR;
  assign w_in = wr_x < 8'(FB_W) && wr_y < 7'(FB_H);
  assign w_last = r_fill == 15'(FB_DEPTH - 1);
  assign wr_ready = !w_clr && !w_disp && !reset;
  assign w_xfer = wr_valid && wr_ready;
  assign mem_addr = w_disp ? w_daddr : w_clr ? r_fill : w_waddr;
  assign mem_we = !reset && !w_disp && (w_clr || (w_xfer && w_in));
  assign mem_wdata = w_clr ? r_color : wr_data;
  assign clear_busy = w_clr;
  assign clear_done = r_done;
  assign wr_drop = r_drop;
  assign pixel_valid = r_slot;
  // read data lands one cycle after the slot; otherwise hold the last pixel, zeroed in blanking
  assign pixel = r_slot ? mem_rdata : r_pixel;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= IDLE;
      r_fill  <= '0;
      r_color <= '0;
      r_pixel <= '0;
      r_slot  <= 1'b0;
      r_done  <= 1'b0;
      r_drop  <= 1'b0;
    end else begin
      r_slot  <= w_disp;
      r_pixel <= nocolor ? '0 : pixel;
      r_done  <= w_clr && !w_disp && w_last;
      if (w_xfer && !w_in) r_drop <= 1'b1;
      if (!w_clr && clear_req) begin
        r_state <= CLEAR;
        r_fill  <= '0;
        r_color <= clear_color;
      end else if (w_clr && !w_disp) begin
        r_fill  <= w_last ? '0 : r_fill + 15'd1;
        r_state <= w_last ? IDLE : CLEAR;
      end
    end
  end
endmodule

// File: tb/tb_vram_arbiter.sv
// tb_vram_arbiter: directed checks of display reads, draw writes, fill and reset behaviour
module tb_vram_arbiter;
  logic        clock = 1'b0, reset = 1'b1, pix_en = 1'b0, nocolor = 1'b1;
  logic [9:0]  xcoord = '0, ycoord = '0;
  logic        wr_valid = 1'b0, clear_req = 1'b0;
  logic [7:0]  wr_x = '0, wr_data = '0, clear_color = '0, mem_rdata = '0;
  logic [6:0]  wr_y = '0;
  logic        wr_ready, clear_busy, clear_done, wr_drop, mem_we, pixel_valid;
  logic [14:0] mem_addr;
  logic [7:0]  mem_wdata, pixel;
  logic [7:0]  mem [0:19199];
  logic        preload = 1'b0, pe, got_done;
  int n_chk = 0, n_fail = 0;
  int bad, slots, pvs, acc, rdy_bad, we_bad, seq_bad, exp_addr, dones;

  vram_arbiter dut (
    .clock(clock), .reset(reset), .pix_en(pix_en), .xcoord(xcoord), .ycoord(ycoord),
    .nocolor(nocolor), .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_x(wr_x), .wr_y(wr_y),
    .wr_data(wr_data), .clear_req(clear_req), .clear_color(clear_color),
    .clear_busy(clear_busy), .clear_done(clear_done), .wr_drop(wr_drop),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .pixel(pixel), .pixel_valid(pixel_valid)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (preload) for (int i = 0; i < 19200; i++) mem[i] <= 8'(i);
    else if (mem_we) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem[mem_addr];
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic p, input logic nc, input logic [9:0] x, input logic [9:0] y);
    pix_en = p;
    nocolor = nc;
    xcoord = x;
    ycoord = y;
    #1;
  endtask

  initial begin
    drive(0, 1, 0, 0);
    check("rst_ready", wr_ready, 0);
    preload = 1'b1;
    tick;
    preload = 1'b0;
    tick;
    check("rst_pixel", pixel, 0);
    check("rst_pv", pixel_valid, 0);
    check("rst_we", mem_we, 0);
    check("rst_busy", clear_busy, 0);
    check("rst_done", clear_done, 0);
    check("rst_drop", wr_drop, 0);
    reset = 1'b0;
    drive(1, 0, 8, 4);
    check("disp_addr", mem_addr, 162);
    check("disp_we", mem_we, 0);
    check("disp_ready", wr_ready, 0);
    tick;
    drive(0, 0, 9, 4);
    check("pix_a2", pixel, 8'hA2);
    check("pv_after_slot", pixel_valid, 1);
    check("wslot_ready", wr_ready, 1);
    tick;
    drive(1, 0, 4, 8);
    check("disp_addr2", mem_addr, 321);
    tick;
    drive(0, 0, 5, 8);
    check("pix_41", pixel, 8'h41);
    tick;
    drive(1, 0, 639, 479);
    check("disp_last", mem_addr, 19199);
    tick;
    drive(0, 0, 0, 0);
    check("pix_ff", pixel, 8'hFF);
    tick;
    drive(1, 1, 0, 0);
    check("blank_ready", wr_ready, 1);
    tick;
    drive(0, 1, 0, 0);
    check("blank_pv", pixel_valid, 0);
    check("blank_pix", pixel, 0);
    tick;
    // draw write held across an active line
    wr_x = 8'd5; wr_y = 7'd3; wr_data = 8'h3C; wr_valid = 1'b1;
    bad = 0; slots = 0; pvs = 0; acc = 0;
    for (int c = 0; c < 16; c++) begin
      pe = (c % 2 == 0);
      drive(pe, 0, 10'(c * 4), 12);
      if (wr_ready !== !pe) bad++;
      if (pixel_valid) pvs++;
      if (pe) slots++;
      if (wr_valid && wr_ready) begin
        acc++;
        if (mem_addr !== 15'd485 || mem_we !== 1'b1 || mem_wdata !== 8'h3C) bad++;
      end
      tick;
      if (acc > 0) wr_valid = 1'b0;
    end
    check("line_bad", bad, 0);
    check("line_acc", acc, 1);
    check("line_pv", pvs, slots);
    check("mem_485", mem[485], 8'h3C);
    // out-of-range writes
    wr_x = 8'd160; wr_y = 7'd0; wr_valid = 1'b1;
    drive(0, 1, 0, 0);
    check("oor_ready", wr_ready, 1);
    check("oor_we", mem_we, 0);
    tick;
    wr_valid = 1'b0;
    check("oor_drop", wr_drop, 1);
    wr_x = 8'd0; wr_y = 7'd120; wr_valid = 1'b1;
    drive(0, 1, 0, 0);
    check("oor_we_y", mem_we, 0);
    tick;
    wr_valid = 1'b0;
    tick; tick; tick;
    check("drop_sticky", wr_drop, 1);
    reset = 1'b1;
    tick;
    reset = 1'b0;
    check("drop_clr", wr_drop, 0);
    // full fill, display preemption early on, stray clear_req mid-fill
    clear_color = 8'h11; clear_req = 1'b1;
    drive(0, 1, 0, 0);
    tick;
    clear_req = 1'b0; clear_color = 8'h55;
    check("clr_busy", clear_busy, 1);
    rdy_bad = 0; we_bad = 0; seq_bad = 0; exp_addr = 0; dones = 0; got_done = 1'b0;
    for (int c = 0; c < 25000; c++) begin
      clear_req = (c == 500);
      pe = (c < 200) && (c % 2 == 0);
      drive(pe, c >= 200, 10'(c % 640), 20);
      if (!clear_busy) begin
        got_done = clear_done;
        break;
      end
      if (wr_ready) rdy_bad++;
      if (pe && mem_we) we_bad++;
      if (clear_done) dones++;
      if (mem_we) begin
        if (mem_addr !== 15'(exp_addr)) seq_bad++;
        exp_addr++;
      end
      tick;
    end
    clear_req = 1'b0;
    check("clr_ready", rdy_bad, 0);
    check("clr_disp_we", we_bad, 0);
    check("clr_seq", seq_bad, 0);
    check("clr_writes", exp_addr, 19200);
    check("clr_done_early", dones, 0);
    check("clr_done", got_done, 1);
    tick;
    check("clr_done_once", clear_done, 0);
    bad = 0;
    for (int i = 0; i < 19200; i++) if (mem[i] !== 8'h11) bad++;
    check("clr_mem", bad, 0);
    // simultaneous write and clear request, then reset mid-fill
    wr_x = 8'd7; wr_y = 7'd0; wr_data = 8'h99; wr_valid = 1'b1;
    clear_req = 1'b1; clear_color = 8'h22;
    drive(0, 1, 0, 0);
    check("both_ready", wr_ready, 1);
    check("both_we", mem_we, 1);
    check("both_addr", mem_addr, 7);
    tick;
    wr_valid = 1'b0; clear_req = 1'b0;
    #1;
    check("both_busy", clear_busy, 1);
    check("both_mem", mem[7], 8'h99);
    check("fill0_addr", mem_addr, 0);
    check("fill0_data", mem_wdata, 8'h22);
    for (int c = 0; c < 2000; c++) begin
      if (mem_addr == 15'd1000) break;
      tick;
    end
    check("at_1000", mem_addr, 1000);
    reset = 1'b1;
    tick;
    reset = 1'b0;
    #1;
    check("abort_busy", clear_busy, 0);
    check("abort_done", clear_done, 0);
    check("abort_ready", wr_ready, 1);
    tick;
    check("abort_done2", clear_done, 0);
    clear_req = 1'b1;
    tick;
    clear_req = 1'b0;
    #1;
    check("restart_busy", clear_busy, 1);
    check("restart_addr", mem_addr, 0);
    reset = 1'b1;
    tick;
    reset = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
